instruct_fetch_buf: RTL and testbench
=====================================

INSTRUCT_FETCH_BUF -- requirements
Module: instruct_fetch_buf

Interface
REQ-001 SHALL have parameter MAX_LENGTH, default 32, giving the width of PC, instruction and offset.
REQ-002 SHALL have parameter QDEPTH, default 4, giving the prefetch queue depth; legal values are powers of two, 2..16.
REQ-003 SHALL have parameter RESET_PC, default 0, giving the first fetch address.
REQ-004 SHALL have parameter PC_STEP, default 4, giving the sequential PC increment in bytes.
REQ-005 SHALL have one clock and one reset: clk input 1, rising-edge clock; reset input 1, asynchronous, active-high.
REQ-006 SHALL have brTaken input 1, redirect request from the execute stage.
REQ-007 SHALL have brPC input MAX_LENGTH, PC of the branch plus PC_STEP.
REQ-008 SHALL have brOffset input MAX_LENGTH, signed word offset.
REQ-009 SHALL have freeze input 1, consumer stall; no pop when high.
REQ-010 SHALL have imem_req output 1, read strobe to instruction memory.
REQ-011 SHALL have imem_addr output MAX_LENGTH, read address.
REQ-012 SHALL have imem_rdata input MAX_LENGTH, read data, valid exactly one cycle after its imem_req.
REQ-013 SHALL have out_valid output 1, queue head holds an instruction.
REQ-014 SHALL have programrun_counter output MAX_LENGTH, PC of the head instruction.
REQ-015 SHALL have instruction output MAX_LENGTH, head instruction word.

Function
REQ-016 SHALL compute the branch target as brPC + (brOffset << 2), truncated to MAX_LENGTH bits, with wrap-around and no overflow flag.
REQ-017 SHALL advance the fetch PC by PC_STEP after each issued request, truncated to MAX_LENGTH bits with wrap-around.
REQ-018 SHALL buffer {pc, instruction} pairs in a FIFO of QDEPTH entries, whose head drives programrun_counter, instruction and out_valid combinationally.
REQ-019 SHALL pop the head in any cycle where out_valid=1 and freeze=0.
REQ-020 SHALL assert imem_req only when count + inflight < QDEPTH, evaluated after that cycle's pop, so the queue never overflows.
REQ-021 SHALL write the response into the queue at the end of the cycle after its request; request at cycle N, rdata at N+1, out_valid at N+2.
REQ-022 SHALL sustain one request per cycle when the consumer pops every cycle.
REQ-023 SHALL implement a 3-state FSM FETCH, FULL, REDIRECT.
REQ-024 SHALL transition FETCH->FULL when the request condition is false.
REQ-025 SHALL transition FULL->FETCH when the condition becomes true.
REQ-026 SHALL transition any state->REDIRECT on brTaken.
REQ-027 SHALL transition REDIRECT->FETCH unconditionally.
REQ-028 SHALL, on brTaken at cycle N, flush all queue entries at the end of N and force out_valid=0 at N+1.
REQ-029 SHALL load the target into the fetch PC.
REQ-030 SHALL issue no request in cycle N itself.
REQ-031 SHALL, in REDIRECT, discard the arriving imem_rdata from any request of cycle N-1 and issue a request at the target; the target instruction becomes valid at N+3.
REQ-032 SHALL give brTaken priority over simultaneous pop, write and freeze, and SHALL ignore freeze for the flush.
REQ-033 SHALL restart a redirect when brTaken arrives while in REDIRECT: the newer target wins and the data from the REDIRECT-cycle request is discarded.
REQ-034 SHALL, when the queue is full and freeze=1, hold all outputs stable and keep imem_req=0.
REQ-035 SHALL, when the queue is empty, drive out_valid=0, and SHALL ignore pops in that state.

Reset
REQ-036 SHALL, while reset=1, set state=FETCH, fetch PC=RESET_PC, count=0 and inflight=0, and drive imem_req=0, out_valid=0, programrun_counter=0 and instruction=0.
REQ-037 SHALL, if reset asserts mid-operation, drop all in-flight data and queue contents.
REQ-038 SHALL issue the first request, with imem_addr=RESET_PC, in the first cycle after reset deasserts.

Structure
REQ-039 SHALL take MAX_LENGTH, RESET_PC, PC_STEP and the FSM state encoding from the shared defines package.
REQ-040 SHALL place the FIFO in one sub-module fetch_queue, parameterised by width and depth, with push, pop, flush, count, empty and full.
REQ-041 SHALL keep target and PC adders inline.

Verification
REQ-042 SHALL cover reset release with freeze=0 and memory returning addr+0x100: imem_addr is 0,4,8,... on consecutive cycles, out_valid rises two cycles after release, and the head shows pc=0 with instruction=0x100.
REQ-043 SHALL cover freeze=1 held for 10 cycles with QDEPTH=4: exactly 4 entries fill (pc 0..12), imem_req=0 afterwards, and the outputs stay at pc=0.
REQ-044 SHALL cover brTaken with brPC=0x20 and brOffset=3 while the queue holds 2 entries: out_valid=0 next cycle, imem_addr=0x2C in the REDIRECT cycle, the stale response is dropped, and the head pc=0x2C appears at N+3.
REQ-045 SHALL cover brTaken with brOffset=-2 (all ones except bit0) and brPC=0x4: the target wraps to 0xFFFFFFFC.
REQ-046 SHALL cover brTaken on two consecutive cycles with targets 0x40 then 0x80: only 0x80-stream instructions ever reach the head.
REQ-047 SHALL cover reset asserted with 3 entries queued and a request in flight: out_valid=0 immediately, and after release fetch restarts at RESET_PC with no stale data.

Source files
------------

// File: rtl/instruct_fetch_buf_pkg.sv
// ============================================================================
// Module   : instruct_fetch_buf_pkg
// Brief    : Shared defaults and FSM state encoding for the fetch buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instruct_fetch_buf_pkg;

    localparam int          C_MAX_LENGTH = 32;
    localparam int          C_QDEPTH     = 4;
    localparam int unsigned C_RESET_PC   = 32'h0000_0000;
    localparam int unsigned C_PC_STEP    = 32'd4;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_FULL     = 2'd1,
        ST_REDIRECT = 2'd2
    } fetch_state_e;

endpackage : instruct_fetch_buf_pkg

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Brief    : Power-of-two depth FIFO with synchronous flush, used as the
//            prefetch queue. Head entry is visible combinationally.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage needs no reset: readers only look at it when count is non-zero.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule : fetch_queue

`default_nettype wire

// File: rtl/instruct_fetch_buf.sv
// ============================================================================
// Module   : instruct_fetch_buf
// Brief    : Instruction prefetch buffer with branch redirect and flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruct_fetch_buf
    import instruct_fetch_buf_pkg::*;
#(
    parameter int                    MAX_LENGTH = C_MAX_LENGTH,
    parameter int                    QDEPTH     = C_QDEPTH,
    parameter logic [MAX_LENGTH-1:0] RESET_PC   = MAX_LENGTH'(C_RESET_PC),
    parameter logic [MAX_LENGTH-1:0] PC_STEP    = MAX_LENGTH'(C_PC_STEP)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  brTaken,
    input  logic [MAX_LENGTH-1:0] brPC,
    input  logic [MAX_LENGTH-1:0] brOffset,
    input  logic                  freeze,
    output logic                  imem_req,
    output logic [MAX_LENGTH-1:0] imem_addr,
    input  logic [MAX_LENGTH-1:0] imem_rdata,
    output logic                  out_valid,
    output logic [MAX_LENGTH-1:0] programrun_counter,
    output logic [MAX_LENGTH-1:0] instruction
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_e            state_q, state_d;
    logic [MAX_LENGTH-1:0]   pc_q, pc_d;
    logic [MAX_LENGTH-1:0]   req_pc_q;
    logic                    inflight_q;

    logic [2*MAX_LENGTH-1:0] w_head;
    logic [CW-1:0]           w_count;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push;
    logic [CW:0]             w_occ;
    logic                    w_room;
    logic                    w_req;
    logic [MAX_LENGTH-1:0]   w_target;

    assign w_target = brPC + (brOffset << 2);

    assign w_pop  = !w_empty && !freeze;
    // A response landing during REDIRECT belongs to an abandoned stream.
    assign w_push = inflight_q && (state_q != ST_REDIRECT) && !brTaken;

    // Occupancy after this cycle's pop and write; a new request needs one slot.
    assign w_occ  = {1'b0, w_count} - (CW+1)'(w_pop) + (CW+1)'(w_push);
    assign w_room = (w_occ < (CW+1)'(QDEPTH)) && !(w_full && freeze);
    assign w_req  = w_room && !brTaken && !reset;

    fetch_queue #(
        .WIDTH (2 * MAX_LENGTH),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (reset),
        .push_i  (w_push),
        .pop_i   (w_pop && !brTaken),
        .flush_i (brTaken),
        .wdata_i ({req_pc_q, imem_rdata}),
        .rdata_o (w_head),
        .count_o (w_count),
        .empty_o (w_empty),
        .full_o  (w_full)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (brTaken) begin
            state_d = ST_REDIRECT;
            pc_d    = w_target;
        end else begin
            case (state_q)
                ST_FETCH:    state_d = w_room ? ST_FETCH : ST_FULL;
                ST_FULL:     state_d = w_room ? ST_FETCH : ST_FULL;
                ST_REDIRECT: state_d = ST_FETCH;
                default:     state_d = ST_FETCH;
            endcase
            if (w_req) pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= w_req;
            if (w_req) req_pc_q <= pc_q;
        end
    end

    assign imem_req           = w_req;
    assign imem_addr          = pc_q;
    assign out_valid          = !w_empty;
    assign programrun_counter = w_empty ? '0 : w_head[2*MAX_LENGTH-1:MAX_LENGTH];
    assign instruction        = w_empty ? '0 : w_head[MAX_LENGTH-1:0];

endmodule : instruct_fetch_buf

`default_nettype wire

// File: tb/tb_instruct_fetch_buf.sv
// ============================================================================
// Module   : tb_instruct_fetch_buf
// Brief    : Directed self-checking bench; memory returns addr + 0x100.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruct_fetch_buf;

    localparam int ML = 32;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          brTaken    = 1'b0;
    logic          freeze     = 1'b0;
    logic [ML-1:0] brPC       = '0;
    logic [ML-1:0] brOffset   = '0;
    logic [ML-1:0] imem_rdata = '0;
    logic          imem_req;
    logic [ML-1:0] imem_addr;
    logic          out_valid;
    logic [ML-1:0] programrun_counter;
    logic [ML-1:0] instruction;

    int n_checks = 0;
    int n_pass   = 0;

    instruct_fetch_buf dut (
        .clk                (clk),
        .reset              (reset),
        .brTaken            (brTaken),
        .brPC               (brPC),
        .brOffset           (brOffset),
        .freeze             (freeze),
        .imem_req           (imem_req),
        .imem_addr          (imem_addr),
        .imem_rdata         (imem_rdata),
        .out_valid          (out_valid),
        .programrun_counter (programrun_counter),
        .instruction        (instruction)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= imem_req ? imem_addr + 32'h100 : 32'hDEAD_BEEF;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [ML-1:0] obs, input logic [ML-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string tag, input logic [ML-1:0] pc);
        logic [ML-1:0] exp_instr;
        exp_instr = pc + 32'h100;
        check({tag, "_valid"}, ML'(out_valid), 32'd1);
        check({tag, "_pc"}, programrun_counter, pc);
        check({tag, "_instr"}, instruction, exp_instr);
    endtask

    task automatic req_at(input string tag, input logic [ML-1:0] addr);
        check({tag, "_req"}, ML'(imem_req), 32'd1);
        check({tag, "_addr"}, imem_addr, addr);
    endtask

    task automatic reset_release(input logic frz);
        reset   = 1'b1;
        brTaken = 1'b0;
        freeze  = frz;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state
        cyc();
        check("rst_req",   ML'(imem_req),  32'd0);
        check("rst_valid", ML'(out_valid), 32'd0);
        check("rst_pc",    programrun_counter, 32'd0);
        check("rst_instr", instruction,        32'd0);

        // Release with freeze low: back-to-back fetch, head two cycles later
        reset_release(1'b0);
        req_at("rel_c0", 32'h0);
        cyc();
        req_at("rel_c1", 32'h4);
        check("rel_c1_valid", ML'(out_valid), 32'd0);
        cyc();
        head("rel_c2", 32'h0);
        req_at("rel_c2", 32'h8);
        cyc();
        head("rel_c3", 32'h4);

        // Freeze for 10 cycles: exactly four entries, then no requests
        reset_release(1'b1);
        for (int i = 1; i <= 9; i++) begin
            cyc();
            if (i >= 4) check($sformatf("frz_c%0d_req", i), ML'(imem_req), 32'd0);
        end
        head("frz_hold", 32'h0);
        cyc();
        freeze = 1'b0;
        #1;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) cyc();
            head($sformatf("drain%0d", k), ML'(4 * k));
        end

        // Redirect with two entries queued: target 0x20 + (3 << 2) = 0x2C
        reset_release(1'b1);
        cyc();
        cyc();
        cyc();
        head("br_pre", 32'h0);
        brTaken  = 1'b1;
        brPC     = 32'h20;
        brOffset = 32'd3;
        #1;
        check("br_n_req", ML'(imem_req), 32'd0);
        cyc();
        brTaken = 1'b0;
        #1;
        check("br_n1_valid", ML'(out_valid), 32'd0);
        req_at("br_n1", 32'h2C);
        cyc();
        check("br_n2_valid", ML'(out_valid), 32'd0);
        cyc();
        head("br_n3", 32'h2C);

        // Negative offset wraps: 0x4 + (0xFFFFFFFE << 2) = 0xFFFFFFFC
        reset_release(1'b0);
        cyc();
        brTaken  = 1'b1;
        brPC     = 32'h4;
        brOffset = 32'hFFFF_FFFE;
        #1;
        cyc();
        brTaken = 1'b0;
        #1;
        req_at("wrap_n1", 32'hFFFF_FFFC);
        cyc();
        req_at("wrap_n2", 32'h0);
        cyc();
        head("wrap_n3", 32'hFFFF_FFFC);
        cyc();
        head("wrap_n4", 32'h0);

        // Back-to-back redirects: 0x40 then 0x80, newer target wins
        reset_release(1'b0);
        cyc();
        brTaken  = 1'b1;
        brPC     = 32'h40;
        brOffset = 32'd0;
        #1;
        cyc();
        brPC = 32'h80;
        #1;
        check("bb_n1_req", ML'(imem_req), 32'd0);
        cyc();
        brTaken = 1'b0;
        #1;
        req_at("bb_n2", 32'h80);
        check("bb_n2_valid", ML'(out_valid), 32'd0);
        cyc();
        check("bb_n3_valid", ML'(out_valid), 32'd0);
        cyc();
        head("bb_n4", 32'h80);
        cyc();
        head("bb_n5", 32'h84);
        cyc();
        head("bb_n6", 32'h88);

        // Reset mid-operation with three entries queued and one in flight
        reset_release(1'b1);
        cyc();
        cyc();
        cyc();
        cyc();
        head("mid_pre", 32'h0);
        reset = 1'b1;
        #1;
        check("mid_valid", ML'(out_valid), 32'd0);
        check("mid_req",   ML'(imem_req),  32'd0);
        check("mid_pc",    programrun_counter, 32'd0);
        check("mid_instr", instruction,        32'd0);
        cyc();
        reset  = 1'b0;
        freeze = 1'b0;
        #1;
        req_at("mid_c0", 32'h0);
        cyc();
        check("mid_c1_valid", ML'(out_valid), 32'd0);
        req_at("mid_c1", 32'h4);
        cyc();
        head("mid_c2", 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_instruct_fetch_buf

`default_nettype wire
